// File: rtl/sample_timestamp_arbiter.sv
// sample_timestamp_arbiter
//   Owns the free-running sample counter on clock48. It holds the counter at
//   zero for a settle delay after reset and then counts every cycle. It hands
//   out counter snapshots to NREQ requesters in round-robin order, delivering
//   each snapshot over a valid/ready port. Counter clears are deferred while
//   a snapshot is outstanding so that a clear never lands mid-delivery.
//
// Ports
//   clock48    in   1     sole clock, posedge
//   rst        in   1     synchronous, active-high reset
//   cnt_clear  in   1     request to zero the counter (level)
//   req        in   NREQ  snapshot requests, held until ack
//   ack        out  NREQ  one-cycle grant pulse (one-hot or zero)
//   ts_valid   out  1     snapshot available on ts_data/ts_id
//   ts_ready   in   1     consumer accepts when ts_valid & ts_ready
//   ts_data    out  CW    captured counter value
//   ts_id      out  3     granted requester index (zero-extended)
//   counts     out  CW    live counter value
//   inited     out  1     settle delay expired
//   cleared    out  1     sticky, a clear has executed since reset
//   wrapped    out  1     one-cycle pulse on all-ones -> 0 rollover
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | settle delay running, counter held at 0, requests ignored
// IDLE  | counting; executes pending clear, else grants a requester
// HOLD  | snapshot presented, waiting for ts_ready; clears deferred

module sample_timestamp_arbiter #(
   parameter int          NREQ        = 4,
   parameter int          CW          = 32,
   parameter logic [31:0] INIT_CYCLES = 32'h3000000
) (
   input  logic            clock48,
   input  logic            rst,
   input  logic            cnt_clear,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] ack,
   output logic            ts_valid,
   input  logic            ts_ready,
   output logic [CW-1:0]   ts_data,
   output logic [2:0]      ts_id,
   output logic [CW-1:0]   counts,
   output logic            inited,
   output logic            cleared,
   output logic            wrapped
);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] initcnt;
   logic [2:0]  rr_ptr;
   logic        clear_pend;

   logic        win_found;
   logic [2:0]  win_idx;
   logic        do_clear;
   logic        do_grant;
   logic        do_accept;
   logic        init_done;

   // Round-robin search: the first requester at distance 0, 1, .. from rr_ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      for (int off = 0; off < NREQ; off++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[k] && (k == (int'(rr_ptr) + off) % NREQ)) begin
               win_found = 1'b1;
               win_idx   = 3'(k);
            end
         end
      end
   end

   always_ff @(posedge clock48) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      do_clear  = 1'b0;
      do_grant  = 1'b0;
      do_accept = 1'b0;
      init_done = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (initcnt == INIT_CYCLES - 32'd1) begin
               init_done = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // A pending or fresh clear always wins over a grant.
            if (cnt_clear || clear_pend) begin
               do_clear = 1'b1;
            end else if (win_found) begin
               do_grant = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ts_ready) begin
               do_accept = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clock48) begin
      if (rst) begin
         initcnt    <= '0;
         counts     <= '0;
         rr_ptr     <= '0;
         clear_pend <= 1'b0;
         ack        <= '0;
         ts_valid   <= 1'b0;
         ts_data    <= '0;
         ts_id      <= '0;
         inited     <= 1'b0;
         cleared    <= 1'b0;
         wrapped    <= 1'b0;
      end else begin
         ack     <= '0;
         wrapped <= 1'b0;

         if (state_q == ST_INIT) initcnt <= initcnt + 32'd1;
         if (init_done)          inited  <= 1'b1;

         if (do_clear) begin
            counts     <= '0;
            cleared    <= 1'b1;
            clear_pend <= 1'b0;
         end else if (inited) begin
            counts  <= counts + 1'b1;
            wrapped <= &counts;
         end

         if (state_q == ST_HOLD && cnt_clear) clear_pend <= 1'b1;

         if (do_grant) begin
            ack      <= NREQ'(1) << win_idx;
            ts_data  <= counts;
            ts_id    <= win_idx;
            ts_valid <= 1'b1;
            rr_ptr   <= (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
         end

         if (do_accept) ts_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sample_timestamp_arbiter.sv
// Bench for sample_timestamp_arbiter: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
// An 8-bit counter is used so rollover is reachable in a few hundred cycles.

module tb_sample_timestamp_arbiter;

   localparam int          NREQ  = 4;
   localparam int          CW    = 8;
   localparam int          INITC = 8;
   localparam int          CMOD  = 1 << CW;

   logic            clock48 = 1'b0;
   logic            rst = 1'b1;
   logic            cnt_clear = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] ack;
   logic            ts_valid;
   logic            ts_ready = 1'b0;
   logic [CW-1:0]   ts_data;
   logic [2:0]      ts_id;
   logic [CW-1:0]   counts;
   logic            inited;
   logic            cleared;
   logic            wrapped;

   sample_timestamp_arbiter #(
      .NREQ        (NREQ),
      .CW          (CW),
      .INIT_CYCLES (32'(INITC))
   ) dut (
      .clock48   (clock48),
      .rst       (rst),
      .cnt_clear (cnt_clear),
      .req       (req),
      .ack       (ack),
      .ts_valid  (ts_valid),
      .ts_ready  (ts_ready),
      .ts_data   (ts_data),
      .ts_id     (ts_id),
      .counts    (counts),
      .inited    (inited),
      .cleared   (cleared),
      .wrapped   (wrapped)
   );

   always #5 clock48 = ~clock48;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Behavioural model: settle counter, snapshot-outstanding flag, deferred clear.
   int  m_settle  = 0;
   bit  m_inited  = 0;
   bit  m_busy    = 0;
   bit  m_pend    = 0;
   int  m_ptr     = 0;
   int  m_cnt     = 0;
   int  m_data    = 0;
   int  m_id      = 0;
   bit  m_valid   = 0;
   int  m_ack     = 0;
   bit  m_cleared = 0;
   bit  m_wrapped = 0;

   task automatic model_step(input bit r, input bit clr, input logic [NREQ-1:0] rq, input bit rdy);
      bit idle;
      bit clear_now;
      int old_cnt;
      if (r) begin
         m_settle = 0; m_inited = 0; m_busy = 0; m_pend = 0; m_ptr = 0;
         m_cnt = 0; m_data = 0; m_id = 0; m_valid = 0; m_ack = 0;
         m_cleared = 0; m_wrapped = 0;
         return;
      end
      m_ack     = 0;
      m_wrapped = 0;
      idle      = m_inited && !m_busy;
      clear_now = idle && (clr || m_pend);
      old_cnt   = m_cnt;
      if (!m_inited) begin
         m_settle++;
         if (m_settle == INITC) m_inited = 1;
      end else if (clear_now) begin
         m_cnt = 0; m_cleared = 1; m_pend = 0;
      end else begin
         m_wrapped = (m_cnt == CMOD - 1);
         m_cnt     = (m_cnt + 1) % CMOD;
      end
      if (m_busy) begin
         if (clr) m_pend = 1;
         if (rdy) begin m_busy = 0; m_valid = 0; end
      end else if (idle && !clear_now && rq != 0) begin
         for (int d = 0; d < NREQ; d++) begin
            int w;
            w = (m_ptr + d) % NREQ;
            if (rq[w]) begin
               m_ack = 1 << w; m_data = old_cnt; m_id = w; m_valid = 1;
               m_busy = 1; m_ptr = (w + 1) % NREQ;
               break;
            end
         end
      end
   endtask

   task automatic cycle(input bit r, input bit clr, input logic [NREQ-1:0] rq, input bit rdy);
      @(negedge clock48);
      rst = r; cnt_clear = clr; req = rq; ts_ready = rdy;
      model_step(r, clr, rq, rdy);
      @(posedge clock48);
      #1;
      chk("ack",      32'(ack),      32'(m_ack));
      chk("ts_valid", 32'(ts_valid), 32'(m_valid));
      chk("ts_data",  32'(ts_data),  32'(m_data));
      chk("ts_id",    32'(ts_id),    32'(m_id));
      chk("counts",   32'(counts),   32'(m_cnt));
      chk("inited",   32'(inited),   32'(m_inited));
      chk("cleared",  32'(cleared),  32'(m_cleared));
      chk("wrapped",  32'(wrapped),  32'(m_wrapped));
   endtask

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin : stim
      int first_ack;
      int first_inited;
      int ids[$];
      int datas[$];
      int d0;
      int npulse;
      int exp_ids[5];
      exp_ids = '{0, 1, 2, 3, 0};

      // Settle delay, single requester held through it.
      cycle(1, 0, '0, 1);
      cycle(1, 0, '0, 1);
      first_ack = -1; first_inited = -1;
      for (int k = 1; k <= 12; k++) begin
         cycle(0, 0, 4'b0001, 1);
         if (inited && first_inited < 0) first_inited = k;
         if (ack != 0 && first_ack < 0) begin
            first_ack = k;
            chk("first_ts_data", 32'(ts_data), 32'd0);
         end
      end
      chk("inited_latency", 32'(first_inited), 32'd8);
      chk("first_ack_latency", 32'(first_ack), 32'd9);

      // Fresh round-robin from pointer 0, all requesting, ready tied high.
      cycle(1, 0, '0, 1);
      for (int k = 0; k < 40 && ids.size() < 5; k++) begin
         cycle(0, 0, 4'b1111, 1);
         if (ack != 0) begin
            ids.push_back(onehot_idx(ack));
            datas.push_back(int'(ts_data));
         end
      end
      chk("rr_grant_count", 32'(ids.size()), 32'd5);
      for (int i = 0; i < ids.size(); i++) chk("rr_order", 32'(ids[i]), 32'(exp_ids[i]));
      for (int i = 1; i < datas.size(); i++)
         chk("rr_ts_spacing", 32'((datas[i] - datas[i-1] + CMOD) % CMOD), 32'd2);

      // Clear and request in the same IDLE cycle: clear first, grant next.
      repeat (3) cycle(0, 0, '0, 1);
      cycle(0, 1, 4'b0100, 1);
      chk("clr_counts", 32'(counts), 32'd0);
      chk("clr_cleared", 32'(cleared), 32'd1);
      chk("clr_no_ack", 32'(ack), 32'd0);
      cycle(0, 0, 4'b0100, 1);
      chk("post_clr_ack", 32'(ack), 32'b0100);
      chk("post_clr_ts", 32'(ts_data), 32'd0);
      repeat (2) cycle(0, 0, '0, 1);

      // Clear during a stalled HOLD is deferred until after acceptance.
      cycle(0, 0, 4'b0001, 0);
      chk("hold_ack", 32'(ack), 32'b0001);
      d0 = int'(ts_data);
      cycle(0, 0, '0, 0);
      cycle(0, 1, '0, 0);
      repeat (3) cycle(0, 0, '0, 0);
      chk("hold_ts_stable", 32'(ts_data), 32'(d0));
      chk("hold_valid", 32'(ts_valid), 32'd1);
      cycle(0, 0, 4'b0010, 1);
      chk("accept_valid", 32'(ts_valid), 32'd0);
      cycle(0, 0, 4'b0010, 1);
      chk("deferred_clr_counts", 32'(counts), 32'd0);
      chk("deferred_clr_no_ack", 32'(ack), 32'd0);
      cycle(0, 0, 4'b0010, 1);
      chk("deferred_then_ack", 32'(ack), 32'b0010);
      repeat (2) cycle(0, 0, '0, 1);

      // Rollover pulses once; a clear from all-ones does not pulse.
      for (int k = 0; k < 300 && m_cnt != CMOD - 2; k++) cycle(0, 0, '0, 1);
      chk("reach_fe", 32'(m_cnt), 32'(CMOD - 2));
      npulse = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(0, 0, '0, 1);
         if (wrapped) npulse++;
      end
      chk("wrap_pulses", 32'(npulse), 32'd1);
      for (int k = 0; k < 300 && m_cnt != CMOD - 1; k++) cycle(0, 0, '0, 1);
      chk("reach_ff", 32'(m_cnt), 32'(CMOD - 1));
      cycle(0, 1, '0, 1);
      chk("clr_no_wrap", 32'(wrapped), 32'd0);
      chk("clr_from_ff", 32'(counts), 32'd0);

      // Reset while a snapshot is held.
      cycle(0, 0, 4'b0100, 0);
      cycle(0, 0, '0, 0);
      cycle(1, 0, '0, 0);
      chk("rst_valid", 32'(ts_valid), 32'd0);
      chk("rst_inited", 32'(inited), 32'd0);
      chk("rst_counts", 32'(counts), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         cycle(0, 0, 4'b1000, 1);
         if (k == 7) chk("reinit_not_yet", 32'(inited), 32'd0);
      end
      chk("reinit_done", 32'(inited), 32'd1);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
               NREQ'($urandom), ($urandom_range(0, 1) == 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
